ds18b20_seq: RTL and testbench

//  Sequencer that drives the 8-bit 1-Wire byte engine (one_wire) through a complete DS18B20 temperature read.

---
 rtl/ds18b20_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_ds18b20_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds18b20_seq.sv
// DS18B20 temperature-read sequencer driving an 8-bit 1-Wire byte engine.
// Optional macro DS_CRC_CHECK_EN: read all 9 scratchpad bytes and check Dallas CRC-8.
module ds18b20_seq #(
  parameter int unsigned CONV_CYCLES = 750000,
  parameter logic [7:0]  CMD_SKIP    = 8'hCC,
  parameter logic [7:0]  CMD_CONV    = 8'h44,
  parameter logic [7:0]  CMD_READ    = 8'hBE
) (
  input  logic        clk,
  input  logic        SRst,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic        NoPresence,
  output logic [15:0] TempData,
  output logic        CrcErr,
  output logic        OwRstN,
  output logic        OwWriteData,
  output logic        OwReadData,
  output logic [7:0]  OwInData,
  input  logic        OwBusy,
  input  logic        OwPresence,
  input  logic [7:0]  OwOutData
);

`ifdef DS_CRC_CHECK_EN
  localparam int unsigned NBYTES = 9;
`else
  localparam int unsigned NBYTES = 2;
`endif
  localparam logic [3:0]  LAST_BYTE = 4'(NBYTES - 1);
  localparam logic [19:0] CONV_LAST = 20'(CONV_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RST1, S_SKIP1, S_CONV, S_WAIT_CONV,
    S_RST2, S_SKIP2, S_RDCMD, S_RDBYTE, S_FINISH
  } state_t;

  typedef enum logic [1:0] {PH_ISSUE, PH_ACK, PH_DONE} phase_t;

  state_t      r_state;
  phase_t      r_ph;
  logic [19:0] r_cnt;
  logic [3:0]  r_idx;
  logic        r_rd_ok;
  logic        r_busy;
  logic        r_done;
  logic        r_nopres;
  logic [15:0] r_temp;
  logic        r_owrstn;
  logic        r_owwr;
  logic        r_owrd;
  logic [7:0]  r_indata;
  logic [7:0]  r_b0;
  logic [7:0]  r_b1;

  logic        w_is_rst;
  logic        w_is_rd;
  logic [7:0]  w_wr_byte;
  logic        w_op_done;
  logic        w_byte_done;
  logic        w_crc_bad;

`ifdef DS_CRC_CHECK_EN
  logic [7:0]  r_crc;
  logic        r_crcerr;

  // Dallas CRC-8, reflected polynomial 0x8C, data shifted in LSB first
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
      else             c = c >> 1;
    end
    return c;
  endfunction

  assign w_crc_bad = (r_crc != 8'h00);
  assign CrcErr    = r_crcerr;
`else
  assign w_crc_bad = 1'b0;
  assign CrcErr    = 1'b0;
`endif

  assign Busy        = r_busy;
  assign Done        = r_done;
  assign NoPresence  = r_nopres;
  assign TempData    = r_temp;
  assign OwRstN      = r_owrstn;
  assign OwWriteData = r_owwr;
  assign OwReadData  = r_owrd;
  assign OwInData    = r_indata;

  always_comb begin
    w_is_rst  = 1'b0;
    w_is_rd   = 1'b0;
    w_wr_byte = 8'h00;
    case (r_state)
      S_RST1, S_RST2:   w_is_rst  = 1'b1;
      S_SKIP1, S_SKIP2: w_wr_byte = CMD_SKIP;
      S_CONV:           w_wr_byte = CMD_CONV;
      S_RDCMD:          w_wr_byte = CMD_READ;
      S_RDBYTE:         w_is_rd   = 1'b1;
      default:          ;
    endcase
  end

  assign w_op_done   = (r_ph == PH_DONE) && !OwBusy;
  assign w_byte_done = (r_state == S_RDBYTE) && w_op_done;

  always_ff @(posedge clk) begin
    if (SRst) begin
      r_state  <= S_IDLE;
      r_ph     <= PH_ISSUE;
      r_cnt    <= 20'd0;
      r_idx    <= 4'd0;
      r_rd_ok  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_nopres <= 1'b0;
      r_temp   <= 16'h0000;
      r_owrstn <= 1'b1;
      r_owwr   <= 1'b0;
      r_owrd   <= 1'b0;
      r_indata <= 8'h00;
`ifdef DS_CRC_CHECK_EN
      r_crcerr <= 1'b0;
`endif
    end else begin
      r_owrstn <= 1'b1;
      r_owwr   <= 1'b0;
      r_owrd   <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start && !r_busy) begin
            r_state  <= S_RST1;
            r_ph     <= PH_ISSUE;
            r_busy   <= 1'b1;
            r_nopres <= 1'b0;
            r_rd_ok  <= 1'b0;
`ifdef DS_CRC_CHECK_EN
            r_crcerr <= 1'b0;
`endif
          end
        end
        S_WAIT_CONV: begin
          if (r_cnt == CONV_LAST) begin
            r_cnt   <= 20'd0;
            r_state <= S_RST2;
            r_ph    <= PH_ISSUE;
          end else begin
            r_cnt <= r_cnt + 20'd1;
          end
        end
        S_FINISH: begin
          if (r_rd_ok && !w_crc_bad) r_temp <= {r_b1, r_b0};
`ifdef DS_CRC_CHECK_EN
          if (r_rd_ok && w_crc_bad) r_crcerr <= 1'b1;
`endif
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          // Engine operation: ISSUE waits for an idle engine, ACK for busy rise, DONE for busy fall
          case (r_ph)
            PH_ISSUE: begin
              if (!OwBusy) begin
                if (w_is_rst) begin
                  r_owrstn <= 1'b0;
                end else if (w_is_rd) begin
                  r_owrd <= 1'b1;
                end else begin
                  r_owwr   <= 1'b1;
                  r_indata <= w_wr_byte;
                end
                r_ph <= PH_ACK;
              end
            end
            PH_ACK: begin
              if (OwBusy) r_ph <= PH_DONE;
            end
            PH_DONE: begin
              if (!OwBusy) begin
                r_ph <= PH_ISSUE;
                case (r_state)
                  S_RST1, S_RST2: begin
                    if (!OwPresence) begin
                      r_nopres <= 1'b1;
                      r_state  <= S_FINISH;
                    end else begin
                      r_state <= (r_state == S_RST1) ? S_SKIP1 : S_SKIP2;
                    end
                  end
                  S_SKIP1: r_state <= S_CONV;
                  S_CONV: begin
                    r_cnt   <= 20'd0;
                    r_state <= S_WAIT_CONV;
                  end
                  S_SKIP2: r_state <= S_RDCMD;
                  S_RDCMD: begin
                    r_idx   <= 4'd0;
                    r_state <= S_RDBYTE;
                  end
                  S_RDBYTE: begin
                    if (r_idx == LAST_BYTE) begin
                      r_rd_ok <= 1'b1;
                      r_state <= S_FINISH;
                    end else begin
                      r_idx <= r_idx + 4'd1;
                    end
                  end
                  default: r_state <= S_IDLE;
                endcase
              end
            end
            default: r_ph <= PH_ISSUE;
          endcase
        end
      endcase
    end
  end

  // Scratchpad capture path (data only, no reset)
  always_ff @(posedge clk) begin
    if (w_byte_done) begin
      if (r_idx == 4'd0) r_b0 <= OwOutData;
      if (r_idx == 4'd1) r_b1 <= OwOutData;
    end
`ifdef DS_CRC_CHECK_EN
    if ((r_state == S_RDCMD) && w_op_done) r_crc <= 8'h00;
    else if (w_byte_done)                  r_crc <= crc8_byte(r_crc, OwOutData);
`endif
  end

endmodule

// File: tb/tb_ds18b20_seq.sv
// Directed bench for ds18b20_seq with a behavioural 1-Wire byte engine model.
// Section 6 is active only when DS_CRC_CHECK_EN is defined for both files.
module tb_ds18b20_seq;
  localparam int CONV = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        SRst = 1'b1;
  logic        Start = 1'b0;
  logic        Busy, Done, NoPresence, CrcErr;
  logic [15:0] TempData;
  logic        OwRstN, OwWriteData, OwReadData;
  logic [7:0]  OwInData;
  logic        ow_busy;
  logic        m_pres = 1'b0;
  logic [7:0]  m_out = 8'h00;

  ds18b20_seq #(.CONV_CYCLES(CONV)) dut (
    .clk(clk), .SRst(SRst), .Start(Start), .Busy(Busy), .Done(Done),
    .NoPresence(NoPresence), .TempData(TempData), .CrcErr(CrcErr),
    .OwRstN(OwRstN), .OwWriteData(OwWriteData), .OwReadData(OwReadData),
    .OwInData(OwInData), .OwBusy(ow_busy), .OwPresence(m_pres), .OwOutData(m_out)
  );

  // Engine model state
  logic       op_busy = 1'b0;
  int         op_timer = 0;
  bit         op_rd = 1'b0;
  int         rd_idx = 0;
  logic       hold_en = 1'b0;
  bit         pres_en = 1'b1;
  logic [7:0] sp [0:8];
  logic [7:0] wlog [0:63];
  int         wcnt = 0;
  int         rst_pulses = 0;
  int         viol_cnt = 0;

  assign ow_busy = op_busy | hold_en;

  always @(posedge clk) begin
    if ((int'(!OwRstN) + int'(OwWriteData) + int'(OwReadData)) > 1) viol_cnt <= viol_cnt + 1;
    else if ((!OwRstN || OwWriteData || OwReadData) && ow_busy) viol_cnt <= viol_cnt + 1;
    if (op_timer != 0) begin
      op_timer <= op_timer - 1;
      if (op_timer == 1) begin
        op_busy <= 1'b0;
        if (op_rd && rd_idx < 9) begin
          m_out  <= sp[rd_idx];
          rd_idx <= rd_idx + 1;
        end
      end
    end else if (!OwRstN) begin
      op_busy <= 1'b1; op_timer <= 12; op_rd <= 1'b0; rd_idx <= 0;
      m_pres <= pres_en;
      rst_pulses <= rst_pulses + 1;
    end else if (OwWriteData) begin
      op_busy <= 1'b1; op_timer <= 9; op_rd <= 1'b0;
      if (wcnt < 64) wlog[wcnt] <= OwInData;
      wcnt <= wcnt + 1;
    end else if (OwReadData) begin
      op_busy <= 1'b1; op_timer <= 9; op_rd <= 1'b1;
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r[0] ^ d[i]) ? ((r >> 1) ^ 8'h8C) : (r >> 1);
    return r;
  endfunction

  task automatic set_sp(input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] c;
    sp[0] = b0; sp[1] = b1; sp[2] = 8'h4B; sp[3] = 8'h46;
    sp[4] = 8'h7F; sp[5] = 8'hFF; sp[6] = 8'h0C; sp[7] = 8'h10;
    c = 8'h00;
    for (int i = 0; i < 8; i++) c = crc8(c, sp[i]);
    sp[8] = c;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start;
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 1);
    if (seen) begin
      chk({tag, "_busy_low_at_done"}, 32'(Busy), 0);
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, 32'(Done), 0);
    end
  endtask

  task automatic chk_writes(input string tag, input int w0);
    logic [7:0] exp [0:3];
    exp[0] = 8'hCC; exp[1] = 8'h44; exp[2] = 8'hCC; exp[3] = 8'hBE;
    chk({tag, "_nwrites"}, 32'(wcnt - w0), 4);
    if (wcnt - w0 == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("%s_wr%0d", tag, i), 32'(wlog[w0 + i]), 32'(exp[i]));
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(Busy), 0);
    chk({tag, "_done"}, 32'(Done), 0);
    chk({tag, "_temp"}, 32'(TempData), 'h0000);
    chk({tag, "_owrstn"}, 32'(OwRstN), 1);
    chk({tag, "_owwr"}, 32'(OwWriteData), 0);
    chk({tag, "_owrd"}, 32'(OwReadData), 0);
    chk({tag, "_nopres"}, 32'(NoPresence), 0);
    chk({tag, "_crcerr"}, 32'(CrcErr), 0);
  endtask

  initial begin
    int  w0;
    int  rp0;
    bit  found;

    set_sp(8'h91, 8'h01);
    tick(3);
    chk_idle_outputs("rst");
    chk("rst_indata", 32'(OwInData), 'h00);
    SRst = 1'b0;
    tick(2);
    chk("rst_idle_busy", 32'(Busy), 0);

    // 1: normal read
    w0 = wcnt;
    pulse_start;
    chk("t1_busy_after_start", 32'(Busy), 1);
    wait_done("t1");
    chk_writes("t1", w0);
    chk("t1_temp", 32'(TempData), 'h0191);
    chk("t1_nopres", 32'(NoPresence), 0);

    // 2: no presence on first reset
    pres_en = 1'b0;
    w0 = wcnt;
    pulse_start;
    wait_done("t2");
    chk("t2_nwrites", 32'(wcnt - w0), 0);
    chk("t2_nopres", 32'(NoPresence), 1);
    chk("t2_temp_kept", 32'(TempData), 'h0191);

    // 3: Start while Busy is ignored
    pres_en = 1'b1;
    set_sp(8'h50, 8'h05);
    w0 = wcnt;
    pulse_start;
    tick(3);
    pulse_start;
    tick(40);
    pulse_start;
    wait_done("t3");
    tick(300);
    chk("t3_idle_after", 32'(Busy), 0);
    chk_writes("t3", w0);
    chk("t3_temp", 32'(TempData), 'h0550);
    chk("t3_nopres_cleared", 32'(NoPresence), 0);

    // 4: SRst during the conversion wait, with Start on the same cycle
    w0 = wcnt;
    pulse_start;
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (wcnt == w0 + 2 && !op_busy) begin
        found = 1'b1;
        break;
      end
    end
    chk("t4_reached_wait", 32'(found), 1);
    tick(50);
    SRst = 1'b1;
    Start = 1'b1;
    @(negedge clk);
    SRst = 1'b0;
    Start = 1'b0;
    chk_idle_outputs("t4_srst");
    tick(2);
    chk("t4_start_with_srst_ignored", 32'(Busy), 0);
    set_sp(8'hF8, 8'hFF);
    w0 = wcnt;
    pulse_start;
    wait_done("t4");
    chk_writes("t4", w0);
    chk("t4_temp", 32'(TempData), 'hFFF8);

    // 5: engine still busy after SRst; first reset pulse must wait
    w0 = wcnt;
    pulse_start;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wcnt == w0 + 1) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_first_write_seen", 32'(found), 1);
    SRst = 1'b1;
    hold_en = 1'b1;
    @(negedge clk);
    SRst = 1'b0;
    chk("t5_srst_busy", 32'(Busy), 0);
    rp0 = rst_pulses;
    w0 = wcnt;
    set_sp(8'h2A, 8'h00);
    pulse_start;
    tick(18);
    chk("t5_no_rst_while_busy", 32'(rst_pulses - rp0), 0);
    chk("t5_owrstn_high", 32'(OwRstN), 1);
    chk("t5_busy_stalled", 32'(Busy), 1);
    hold_en = 1'b0;
    wait_done("t5");
    chk("t5_rst_pulses", 32'(rst_pulses - rp0), 2);
    chk_writes("t5", w0);
    chk("t5_temp", 32'(TempData), 'h002A);

`ifdef DS_CRC_CHECK_EN
    // 6: CRC good, then CRC bad
    set_sp(8'h91, 8'h01);
    pulse_start;
    wait_done("t6a");
    chk("t6a_crcerr", 32'(CrcErr), 0);
    chk("t6a_temp", 32'(TempData), 'h0191);
    set_sp(8'h55, 8'h02);
    sp[2] = sp[2] ^ 8'h01;
    pulse_start;
    wait_done("t6b");
    chk("t6b_crcerr", 32'(CrcErr), 1);
    chk("t6b_temp_kept", 32'(TempData), 'h0191);
`endif

    chk("protocol_violations", 32'(viol_cnt), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
